// File: rtl/bus_pkg.sv
// Shared bus widths, grant encodings and arbiter state types for the
// two-master slave-port arbiter.
package bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } arb_state_e;

   // Master preferred on the next simultaneous request.
   typedef enum logic {
      PtrM0 = 1'b0,
      PtrM1 = 1'b1
   } rr_ptr_e;

endpackage

// File: rtl/bus_watchdog.sv
// Slave-response watchdog: counts BUSY cycles without completion and flags
// expiry on the last allowed cycle. TIMEOUT_CYCLES = 0 disables it.
module bus_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic active,
   input  logic done,
   output logic expire
);

   localparam bit          Enabled = (TIMEOUT_CYCLES != 0);
   localparam int unsigned CntW    = Enabled ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast = Enabled ? CntW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Saturating count so a disabled or stalled watchdog never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = '0;
      end else if (active && !done && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = Enabled && active && !done && (cnt_q == CntLast);

endmodule

// File: rtl/bus_rr_arbiter.sv
// Two-master round-robin arbiter for one downstream slave port. One
// transaction at a time, one idle cycle between grants, watchdog-forced error.
module bus_rr_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 256,
   parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic              m0_write,
   input  logic              m0_enable,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic              m1_write,
   input  logic              m1_enable,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_ready,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   output logic              s_write,
   output logic              s_enable,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_ready,
   output logic [1:0]        grant,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] err_addr
);

   arb_state_e        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   rr_ptr_e           rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              busy, any_req, wd_start, expire, done;
   logic [ADDR_W-1:0] owner_addr;

   assign busy       = (state_q == StBusy);
   assign any_req    = m0_enable | m1_enable;
   assign wd_start   = (state_q == StIdle) && any_req;
   assign done       = busy && (s_ready || expire);
   assign owner_addr = grant_q[1] ? m1_addr : m0_addr;

   bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .rst_n (rst_n),
      .start (wd_start),
      .active(busy),
      .done  (s_ready),
      .expire(expire)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      err_addr_d = err_addr_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = StBusy;
               if (m0_enable && m1_enable) begin
                  grant_d = (rr_ptr_q == PtrM0) ? GRANT_M0 : GRANT_M1;
               end else begin
                  grant_d = m0_enable ? GRANT_M0 : GRANT_M1;
               end
            end
         end
         StBusy: begin
            // Enable drops by the owner are ignored; only completion or expiry ends it.
            if (done) begin
               state_d  = StIdle;
               grant_d  = GRANT_NONE;
               rr_ptr_d = grant_q[0] ? PtrM1 : PtrM0;
               if (expire) begin
                  err_addr_d = owner_addr;
               end
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = GRANT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         grant_q    <= GRANT_NONE;
         rr_ptr_q   <= PtrM0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      s_write     = 1'b0;
      s_enable    = 1'b0;
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      m0_rdata    = '0;
      m1_rdata    = '0;
      timeout_err = 1'b0;
      if (busy) begin
         s_enable    = !expire;
         s_addr      = owner_addr;
         s_wdata     = grant_q[1] ? m1_wdata : m0_wdata;
         s_wstrb     = grant_q[1] ? m1_wstrb : m0_wstrb;
         s_write     = grant_q[1] ? m1_write : m0_write;
         m0_ready    = grant_q[0] && done;
         m1_ready    = grant_q[1] && done;
         timeout_err = expire;
         if (m0_ready) begin
            m0_rdata = expire ? ERR_RDATA : s_rdata;
         end
         if (m1_ready) begin
            m1_rdata = expire ? ERR_RDATA : s_rdata;
         end
      end
   end

   assign grant    = grant_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized bench for bus_rr_arbiter against a transaction-level model of
// ownership, round-robin preference and watchdog age.
module tb_bus_rr_arbiter;

   localparam int unsigned TO   = 8;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr[2];
   logic [31:0] wdata[2];
   logic [3:0]  strb[2];
   logic        wr[2];
   logic        en[2];
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata, err_addr;
   logic [3:0]  s_wstrb;
   logic        m0_ready, m1_ready, s_write, s_enable, s_ready, timeout_err;
   logic [1:0]  grant;

   always #5 clk = ~clk;

   bus_rr_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .ERR_RDATA     (ERRD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0_addr    (addr[0]),
      .m0_wdata   (wdata[0]),
      .m0_wstrb   (strb[0]),
      .m0_write   (wr[0]),
      .m0_enable  (en[0]),
      .m0_rdata   (m0_rdata),
      .m0_ready   (m0_ready),
      .m1_addr    (addr[1]),
      .m1_wdata   (wdata[1]),
      .m1_wstrb   (strb[1]),
      .m1_write   (wr[1]),
      .m1_enable  (en[1]),
      .m1_rdata   (m1_rdata),
      .m1_ready   (m1_ready),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_write    (s_write),
      .s_enable   (s_enable),
      .s_rdata    (s_rdata),
      .s_ready    (s_ready),
      .grant      (grant),
      .timeout_err(timeout_err),
      .err_addr   (err_addr)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: who owns the slave, how long it has waited, who is next.
   int          owner = -1;
   int          waited = 0;
   int          pref = 0;
   logic [31:0] m_err_addr = '0;
   bit          pend[2];
   bit          rel[2];

   task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner      = -1;
      waited     = 0;
      pref       = 0;
      m_err_addr = '0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         rel[i]  = 1'b0;
         en[i]   = 1'b0;
      end
   endtask

   task automatic new_req(input int i);
      pend[i]  = 1'b1;
      en[i]    = 1'b1;
      addr[i]  = $urandom;
      wdata[i] = $urandom;
      strb[i]  = 4'($urandom);
      wr[i]    = 1'($urandom);
   endtask

   task automatic drive(input int req_pct, input int rdy_pct);
      for (int i = 0; i < 2; i++) begin
         if (rel[i]) begin
            rel[i]  = 1'b0;
            pend[i] = 1'b0;
            en[i]   = 1'b0;
         end
         if (!pend[i] && ($urandom_range(0, 99) < req_pct)) begin
            new_req(i);
         end else if (owner == i && $urandom_range(0, 99) < 3) begin
            en[i] = 1'b0;  // misbehaving owner; arbiter must keep the grant
         end
      end
      if (owner >= 0 && waited == TO - 1) begin
         s_ready = 1'($urandom);
      end else begin
         s_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      s_rdata = $urandom;
   endtask

   task automatic check_cycle();
      logic [1:0]  eg;
      logic        e_en, e_wr, tmo, done;
      logic [31:0] ea, ed;
      logic [3:0]  es;
      logic [31:0] erd[2];
      logic        erdy[2];
      eg = 2'b00; e_en = 1'b0; e_wr = 1'b0; tmo = 1'b0; done = 1'b0;
      ea = '0; ed = '0; es = '0;
      erd[0] = '0; erd[1] = '0; erdy[0] = 1'b0; erdy[1] = 1'b0;
      if (owner >= 0) begin
         tmo   = !s_ready && (waited == TO - 1);
         done  = s_ready || tmo;
         eg    = (owner == 0) ? 2'b01 : 2'b10;
         e_en  = !tmo;
         ea    = addr[owner];
         ed    = wdata[owner];
         es    = strb[owner];
         e_wr  = wr[owner];
         erdy[owner] = done;
         erd[owner]  = s_ready ? s_rdata : (tmo ? ERRD : 32'h0);
      end
      check_val("grant", 96'(grant), 96'(eg));
      check_val("s_bus", 96'({s_enable, s_write, s_wstrb, s_addr, s_wdata}),
                96'({e_en, e_wr, es, ea, ed}));
      check_val("ready", 96'({m0_ready, m1_ready, timeout_err}), 96'({erdy[0], erdy[1], tmo}));
      check_val("rdata", 96'({m0_rdata, m1_rdata}), 96'({erd[0], erd[1]}));
      check_val("err_addr", 96'(err_addr), 96'(m_err_addr));
      if (owner >= 0) begin
         if (done) begin
            if (tmo) m_err_addr = addr[owner];
            rel[owner] = 1'b1;
            pref  = 1 - owner;
            owner = -1;
         end else begin
            waited++;
         end
      end else if (en[0] || en[1]) begin
         owner  = (en[0] && en[1]) ? pref : (en[0] ? 0 : 1);
         waited = 0;
      end
   endtask

   task automatic run(input int cycles, input int req_pct, input int rdy_pct);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         drive(req_pct, rdy_pct);
         #1;
         check_cycle();
      end
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0; wdata[i] = '0; strb[i] = '0; wr[i] = 1'b0;
      end
      s_ready = 1'b0;
      s_rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      s_ready = 1'b1;  // ignored while idle and in reset
      s_rdata = 32'h1234_5678;
      check_cycle();
      @(posedge clk);
      #3 rst_n = 1'b1;

      run(400, 30, 40);
      run(300, 100, 50);  // both always requesting: strict alternation
      run(300, 60, 0);    // mostly timeouts
      run(300, 100, 10);
      run(300, 40, 70);

      // Reset in the middle of a transaction.
      guard = 0;
      while (owner < 0 && guard < 50) begin
         run(1, 100, 0);
         guard++;
      end
      check_val("reach_busy", 96'(owner >= 0), 96'(1));
      @(posedge clk);
      #1 s_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_async", 96'({s_enable, grant, m0_ready, m1_ready}), 96'(0));
      model_reset();
      @(posedge clk);
      #1;
      new_req(0);
      new_req(1);
      s_ready = 1'b0;
      rst_n = 1'b1;
      #1;
      check_cycle();
      run(200, 100, 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
